led_fade_pwm: RTL

PL-side stage directly downstream of the PS AXI GPIO LED word (led_tri_o) and upstream of the board LED pins. Converts each on/off request bit into a PWM-driven LED that ramps its brightness up or down in fixed steps, once per PWM period. A bypass mode passes the raw request bits straight through.

---
 rtl/led_fade_pwm_if.sv | 26 ++
 rtl/led_fade_pwm.sv | 85 ++++++++
 2 files changed

// File: rtl/led_fade_pwm_if.sv
// rtl/led_fade_pwm_if.sv - LED request/drive bundle between GPIO word and LED pins
interface led_fade_pwm_if #(
  parameter int N_LED = 4
);
  logic [N_LED-1:0] led_req;
  logic             bypass;
  logic [N_LED-1:0] led_o;
  logic [N_LED-1:0] busy;
  logic             period_strobe;

  modport master (
    output led_req,
    output bypass,
    input  led_o,
    input  busy,
    input  period_strobe
  );

  modport slave (
    input  led_req,
    input  bypass,
    output led_o,
    output busy,
    output period_strobe
  );
endinterface

// File: rtl/led_fade_pwm.sv
// rtl/led_fade_pwm.sv - per-LED PWM brightness ramp with raw bypass
module led_fade_pwm #(
  parameter int N_LED    = 4,
  parameter int PWM_BITS = 8,
  parameter int PWM_DIV  = 256,
  parameter int STEP     = 1
) (
  input  logic           aclk,
  input  logic           aresetn,
  led_fade_pwm_if.slave  bus
);

  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(PWM_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX_L    = '1;
  localparam logic [PWM_BITS-1:0] STEP_L   = PWM_BITS'(STEP);
  localparam logic [PWM_BITS:0]   STEP_X   = (PWM_BITS + 1)'(STEP);
  localparam logic [PWM_BITS:0]   MAX_X    = {1'b0, MAX_L};

  logic [DIV_W-1:0]    div_q, div_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] level_q [N_LED];
  logic [PWM_BITS-1:0] level_d [N_LED];
  logic [PWM_BITS:0]   sum_w   [N_LED];
  logic [N_LED-1:0]    led_o_q, led_o_d;
  logic [N_LED-1:0]    busy_q, busy_d;
  logic                strobe_q, strobe_d;
  logic                tick;
  logic                end_of_period;

  always_comb begin
    tick          = (div_q == DIV_LAST);
    div_d         = tick ? '0 : div_q + 1'b1;
    pwm_cnt_d     = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end_of_period = tick && (pwm_cnt_q == MAX_L);
    strobe_d      = end_of_period;

    for (int i = 0; i < N_LED; i++) begin
      // Extra bit catches the overshoot past MAX before saturating.
      sum_w[i]   = {1'b0, level_q[i]} + STEP_X;
      level_d[i] = level_q[i];
      if (end_of_period) begin
        if (bus.led_req[i] && level_q[i] != MAX_L) begin
          level_d[i] = (sum_w[i] > MAX_X) ? MAX_L : sum_w[i][PWM_BITS-1:0];
        end else if (!bus.led_req[i] && level_q[i] != '0) begin
          level_d[i] = (level_q[i] >= STEP_L) ? level_q[i] - STEP_L : '0;
        end
      end

      if (bus.bypass) begin
        led_o_d[i] = bus.led_req[i];
      end else begin
        led_o_d[i] = (level_q[i] == MAX_L) || (pwm_cnt_q < level_q[i]);
      end
      busy_d[i] = bus.led_req[i] ? (level_q[i] != MAX_L) : (level_q[i] != '0);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      div_q     <= '0;
      pwm_cnt_q <= '0;
      led_o_q   <= '0;
      busy_q    <= '0;
      strobe_q  <= 1'b0;
      for (int i = 0; i < N_LED; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      div_q     <= div_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_o_q   <= led_o_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
      for (int i = 0; i < N_LED; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign bus.led_o         = led_o_q;
  assign bus.busy          = busy_q;
  assign bus.period_strobe = strobe_q;

endmodule
